// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory fetch bus: request/address out, ready/data back.
// master = fetch controller, slave = instruction memory.
interface if_fetch_ctrl_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdy,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdy,
    output imem_data
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, runs the imem req/rdy
// handshake, handles jump/stall/halt, discards stale in-flight fetches
// and counts miss cycles.
// Ports: clk, rst (sync, active-high); Mode (1=run), stall, jump,
// jump_target; imem (master: req/addr out, rdy/data in);
// instr_i/i_hit to IF mux; pc_o, pc_plus1 (link); miss_cycles.
module if_fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Mode,
  input  logic        stall,
  input  logic        jump,
  input  logic [15:0] jump_target,
  if_fetch_ctrl_if.master imem,
  output logic [15:0] instr_i,
  output logic        i_hit,
  output logic [15:0] pc_o,
  output logic [15:0] pc_plus1,
  output logic [15:0] miss_cycles
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        redir_pend_q, redir_pend_d;
  logic [15:0] redir_pc_q, redir_pc_d;
  logic [15:0] miss_q, miss_d;

  logic [15:0] pc_cur;
  logic [15:0] pc_hit_nxt;
  logic        req;

  // While rst is high the outputs already show the reset PC.
  assign pc_cur   = rst ? RESET_PC : pc_q;
  assign pc_o     = pc_cur;
  assign pc_plus1 = pc_cur + 16'd1;

  assign imem.imem_addr = pc_cur;
  assign imem.imem_req  = req;

  assign miss_cycles = miss_q;

  // PC update on an accepted word: jump > stall > advance.
  assign pc_hit_nxt = jump  ? jump_target :
                      stall ? pc_q        :
                              pc_q + 16'd1;

  always_comb begin
    req = 1'b0;
    if (!rst) begin
      req = (state_q == FETCH) ? Mode : 1'b1;
    end
  end

  assign i_hit   = imem.imem_rdy & req & (state_q != DISCARD);
  assign instr_i = i_hit ? imem.imem_data : 16'h0000;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redir_pend_d = redir_pend_q;
    redir_pc_d   = redir_pc_q;
    miss_d       = miss_q;

    unique case (state_q)
      FETCH: begin
        if (!Mode) begin
          if (jump) pc_d = jump_target;
        end else if (imem.imem_rdy) begin
          pc_d = pc_hit_nxt;
        end else if (jump) begin
          pc_d = jump_target;
        end else begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (miss_q != 16'hFFFF) miss_d = miss_q + 16'd1;
        if (imem.imem_rdy) begin
          pc_d    = pc_hit_nxt;
          state_d = FETCH;
        end else if (jump || !Mode) begin
          state_d      = DISCARD;
          redir_pend_d = jump;
          if (jump) redir_pc_d = jump_target;
        end
      end

      DISCARD: begin
        if (jump) begin
          redir_pend_d = 1'b1;
          redir_pc_d   = jump_target;
        end
        if (imem.imem_rdy) begin
          if (jump)              pc_d = jump_target;
          else if (redir_pend_q) pc_d = redir_pc_q;
          redir_pend_d = 1'b0;
          state_d      = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= 16'h0000;
      miss_q       <= 16'h0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
      miss_q       <= miss_d;
    end
  end

endmodule
